// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire post-synaptic neuron with a refractory period.
// Optional macro LIF_LEAK_EN enables the v >> LEAK_SHIFT leak term.
module lif_post_neuron #(
    parameter int unsigned          NUM_PRE        = 4,
    parameter int unsigned          W_WIDTH        = 4,
    parameter int unsigned          V_WIDTH        = 8,
    parameter logic [V_WIDTH-1:0]   THRESHOLD      = 8'd16,
    parameter int unsigned          LEAK_SHIFT     = 3,
    parameter int unsigned          REFRACT_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_PRE-1:0]           pre_spike,
    input  logic [NUM_PRE*W_WIDTH-1:0]   weight,
    output logic                         post_spike,
    output logic [V_WIDTH-1:0]           membrane,
    output logic                         refractory
);

    localparam int unsigned SUM_W = V_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(REFRACT_CYCLES + 1);
    localparam logic [SUM_W-1:0] V_MAX = {1'b0, {V_WIDTH{1'b1}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_INTEG   = 2'd1;
    localparam logic [1:0] S_REFRACT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [V_WIDTH-1:0] v_d;
    logic               spike_d, refr_d;

    logic [SUM_W-1:0]   syn;
    logic [SUM_W-1:0]   v_sum;
    logic [V_WIDTH-1:0] v_sat;
    logic               fire;

    // Weight of line i sits in the i-th nibble from the MSB end.
    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < NUM_PRE; i++) begin
            if (pre_spike[i]) begin
                syn = syn + SUM_W'(weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
            end
        end
    end

`ifdef LIF_LEAK_EN
    assign v_sum = SUM_W'(membrane) - SUM_W'(membrane >> LEAK_SHIFT) + syn;
`else
    assign v_sum = SUM_W'(membrane) + syn;
`endif

    assign v_sat = (v_sum > V_MAX) ? V_WIDTH'(V_MAX) : V_WIDTH'(v_sum);
    assign fire  = (v_sat >= THRESHOLD);

    // Next-state and registered-output values; everything holds while en is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = membrane;
        spike_d = 1'b0;
        refr_d  = refractory;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_INTEG;
                end
                S_INTEG: begin
                    if (fire) begin
                        state_d = S_REFRACT;
                        v_d     = '0;
                        spike_d = 1'b1;
                        refr_d  = 1'b1;
                        cnt_d   = CNT_W'(REFRACT_CYCLES);
                    end else begin
                        v_d = v_sat;
                    end
                end
                S_REFRACT: begin
                    v_d = '0;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_INTEG;
                        refr_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    v_d     = '0;
                    refr_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            membrane   <= '0;
            post_spike <= 1'b0;
            refractory <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            membrane   <= v_d;
            post_spike <= spike_d;
            refractory <= refr_d;
        end
    end

endmodule

// File: tb/tb_lif_post_neuron.sv
// Scoreboard bench for lif_post_neuron: two instances (threshold 16 and 250)
// checked every cycle against a behavioural neuron model.
module tb_lif_post_neuron;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  pre_spike = '0;
    logic [15:0] weight = '0;

    logic        post_a, refr_a, post_b, refr_b;
    logic [7:0]  mem_a, mem_b;

    always #5 clk = ~clk;

    lif_post_neuron #(.THRESHOLD(8'd16)) u_a (
        .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
        .post_spike(post_a), .membrane(mem_a), .refractory(refr_a)
    );

    lif_post_neuron #(.THRESHOLD(8'd250)) u_b (
        .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
        .post_spike(post_b), .membrane(mem_b), .refractory(refr_b)
    );

    // mode: 0 idle, 1 integrating, 2 refractory (cycles_left counts down to 0)
    typedef struct {
        int mode;
        int v;
        int cycles_left;
        bit post;
        bit refr;
    } model_t;

    typedef struct {
        bit post;
        int v;
        bit refr;
    } exp_t;

    model_t ma, mb;
    exp_t   q_a[$];
    exp_t   q_b[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic model_t model_next(model_t s, int thr, bit r, bit e,
                                          logic [3:0] pre, logic [15:0] w);
        model_t n = s;
        int syn, leak, vn;
        n.post = 1'b0;
        if (r) begin
            n.mode = 0; n.v = 0; n.cycles_left = 0; n.refr = 1'b0;
            return n;
        end
        if (!e) return n;
        case (s.mode)
            0: n.mode = 1;
            1: begin
                syn = 0;
                for (int i = 0; i < 4; i++)
                    if (pre[i]) syn += int'((w >> (4 * (3 - i))) & 16'hF);
                leak = 0;
`ifdef LIF_LEAK_EN
                leak = s.v / 8;
`endif
                vn = s.v - leak + syn;
                if (vn > 255) vn = 255;
                if (vn >= thr) begin
                    n.post = 1'b1; n.v = 0; n.mode = 2; n.cycles_left = 4; n.refr = 1'b1;
                end else begin
                    n.v = vn;
                end
            end
            default: begin
                n.v = 0;
                n.cycles_left = s.cycles_left - 1;
                if (n.cycles_left == 0) begin
                    n.mode = 1; n.refr = 1'b0;
                end
            end
        endcase
        return n;
    endfunction

    task automatic step(input bit r, input bit e, input logic [3:0] p, input logic [15:0] w);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; pre_spike = p; weight = w;
        @(posedge clk);
        ma = model_next(ma, 16, r, e, p, w);
        mb = model_next(mb, 250, r, e, p, w);
        x.post = ma.post; x.v = ma.v; x.refr = ma.refr;
        q_a.push_back(x);
        x.post = mb.post; x.v = mb.v; x.refr = mb.refr;
        q_b.push_back(x);
    endtask

    task automatic check(input string name, input exp_t x, input logic p,
                         input logic [7:0] m, input logic r);
        n_cmp++;
        if (p !== x.post || m !== 8'(x.v) || r !== x.refr) begin
            n_bad++;
            $display("FAIL %s t=%0t: got post=%b mem=%0d refr=%b, expected post=%b mem=%0d refr=%b",
                     name, $time, p, m, r, x.post, x.v, x.refr);
        end
    endtask

    // Monitor: one expected sample per clock for each instance.
    always @(negedge clk) begin
        exp_t x;
        if (q_a.size() > 0) begin
            x = q_a.pop_front();
            check("thr16", x, post_a, mem_a, refr_a);
        end
        if (q_b.size() > 0) begin
            x = q_b.pop_front();
            check("thr250", x, post_b, mem_b, refr_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  p;
        logic [15:0] w;
        bit          r, e;

        // Reset then first enabled edge (IDLE -> INTEGRATE only)
        step(1, 0, 4'b0000, 16'h0000);
        step(1, 1, 4'b0001, 16'hF000);
        step(0, 1, 4'b0001, 16'hF000);
        // Threshold crossing and refractory window
        repeat (10) step(0, 1, 4'b0001, 16'hF000);

        // Simultaneous inputs: syn = 16
        step(1, 0, 4'b0000, 16'h0000);
        step(0, 1, 4'b1111, 16'h4444);
        repeat (3) step(0, 1, 4'b1111, 16'h4444);

        // Saturation path on the 250-threshold instance
        step(1, 0, 4'b0000, 16'h0000);
        step(0, 1, 4'b1111, 16'hFFFF);
        repeat (7) step(0, 1, 4'b1111, 16'hFFFF);

        // Single spike then quiet: holds, or decays under leak
        step(1, 0, 4'b0000, 16'h0000);
        step(0, 1, 4'b0000, 16'h0000);
        step(0, 1, 4'b0001, 16'hF000);
        repeat (12) step(0, 1, 4'b0000, 16'h0000);

        // Hold during refractory, then abort with reset
        step(0, 1, 4'b0011, 16'hFF00);
        step(0, 1, 4'b0011, 16'hFF00);
        repeat (3) step(0, 0, 4'b1111, 16'hFFFF);
        step(0, 1, 4'b0000, 16'h0000);
        repeat (2) step(0, 0, 4'b0000, 16'h0000);
        step(1, 1, 4'b1111, 16'hFFFF);
        step(0, 0, 4'b0000, 16'h0000);
        repeat (8) step(0, 1, 4'b0001, 16'h8000);

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 9) != 0);
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            w = 16'($urandom);
            step(r, e, p, w);
        end

        repeat (2) @(negedge clk);
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
